rob_commit_ctrl: RTL

Sequences in-order retirement from the ROB head in the OoO RV32I core. Each cycle it decides whether the head entry may retire and pulses dequeue to the ROB. It drives the architectural regfile/RAT write port and gates stores against the store buffer. On a taken branch/jump it raises the pipeline-wide flush and the redirect PC, then holds commit for a fixed drain window.

---
 rtl/rv32i_types.sv | 21 ++
 rtl/rob_commit_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types: commit FSM states and the retire record that the
// commit controller drives and the RVFI monitor consumes.
package rv32i_types;

   localparam int unsigned COMMIT_ORDER_W = 64;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } commit_state_t;

   typedef struct packed {
      logic                      we;
      logic [4:0]                rd_addr;
      logic [31:0]               rd_data;
      logic [4:0]                rob_idx;
      logic                      valid;
      logic [COMMIT_ORDER_W-1:0] order;
   } commit_out_t;

endpackage

// File: rtl/rob_commit_ctrl.sv
// In-order retirement from the ROB head: one commit per cycle, store gating,
// and a flush/redirect followed by a fixed commit-free drain window.
module rob_commit_ctrl
   import rv32i_types::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned ORDER_W      = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rob_empty_i,
   input  logic               head_valid_i,
   input  logic               head_done_i,
   input  logic [4:0]         head_rob_idx_i,
   input  logic [31:0]        head_pc_i,
   input  logic               head_regf_we_i,
   input  logic [4:0]         head_rd_addr_i,
   input  logic [31:0]        head_rd_data_i,
   input  logic               head_is_br_i,
   input  logic               head_br_en_i,
   input  logic [31:0]        head_pc_new_i,
   input  logic               head_is_store_i,
   input  logic               store_ack_i,
   output logic               dequeue_o,
   output logic               rf_we_o,
   output logic [4:0]         rf_rd_addr_o,
   output logic [31:0]        rf_rd_data_o,
   output logic [4:0]         rf_rob_idx_o,
   output logic               store_commit_o,
   output logic               flush_o,
   output logic [31:0]        redirect_pc_o,
   output logic               commit_valid_o,
   output logic [ORDER_W-1:0] commit_order_o
);

   commit_state_t      r_state;
   logic [3:0]         r_drain;
   logic [ORDER_W-1:0] r_order_cnt;
   commit_out_t        r_out;
   logic               r_flush;
   logic [31:0]        r_redirect;

   logic w_can_commit;
   logic w_mispredict;
   logic w_unused;

   // head_pc_i is only of interest to trace/debug consumers
   assign w_unused = ^head_pc_i;

   assign w_can_commit = (r_state == RUN) & ~rob_empty_i & head_valid_i & head_done_i &
                         (~head_is_store_i | store_ack_i);
   assign w_mispredict = w_can_commit & head_is_br_i & head_br_en_i;

   assign dequeue_o      = w_can_commit;
   assign store_commit_o = w_can_commit & head_is_store_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RUN;
         r_drain     <= 4'd0;
         r_order_cnt <= '0;
         r_out       <= '0;
         r_flush     <= 1'b0;
         r_redirect  <= 32'd0;
      end else begin
         r_out.valid <= w_can_commit;
         r_out.we    <= w_can_commit & head_regf_we_i & (head_rd_addr_i != 5'd0);
         r_flush     <= w_mispredict;
         if (w_can_commit) begin
            r_out.rd_addr <= head_rd_addr_i;
            r_out.rd_data <= head_rd_data_i;
            r_out.rob_idx <= head_rob_idx_i;
            r_out.order   <= COMMIT_ORDER_W'(r_order_cnt);
            r_order_cnt   <= r_order_cnt + 1'b1;
         end
         if (w_mispredict)
            r_redirect <= head_pc_new_i;
         case (r_state)
            RUN: begin
               if (w_mispredict) begin
                  r_state <= FLUSH;
                  r_drain <= 4'(FLUSH_CYCLES);
               end
            end
            FLUSH: begin
               // the flush_o cycle is the first of the FLUSH_CYCLES drain cycles
               if (r_drain <= 4'd1) begin
                  r_state <= RUN;
                  r_drain <= 4'd0;
               end else begin
                  r_drain <= r_drain - 4'd1;
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign rf_we_o        = r_out.we;
   assign rf_rd_addr_o   = r_out.rd_addr;
   assign rf_rd_data_o   = r_out.rd_data;
   assign rf_rob_idx_o   = r_out.rob_idx;
   assign commit_valid_o = r_out.valid;
   assign commit_order_o = r_out.order[ORDER_W-1:0];
   assign flush_o        = r_flush;
   assign redirect_pc_o  = r_redirect;

endmodule
